frame_loader: RTL and testbench
===============================

# frame_loader

Fills the 128×8 frame RAM from an incoming byte stream. It writes through the same two-phase `ram_clk` strobe protocol that the display scan path uses for reading. It sits between the byte source (host link / pattern source) and the frame RAM, and it owns the RAM port while a frame is being loaded. It accepts bytes on a valid/ready handshake, writes them to consecutive addresses 0..MAX_ADDR, and flags completion.

## Interface
- `DW`, 8, data width
- `AW`, 8, address width
- `MAX_ADDR`, 8'd127, last RAM address of a frame
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-low
- `start`  in  1  one-cycle pulse that begins a new frame load at address 0
- `in_data`  in  DW  byte from the source
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader can accept a byte this cycle
- `ram_din`  out  DW  write data to RAM
- `ram_addr`  out  AW  RAM address
- `ram_we`  out  1  RAM write enable
- `ram_clk`  out  1  RAM strobe; the RAM captures on its rising edge
- `busy`  out  1  frame load in progress
- `done`  out  1  sticky; frame fully written
- `err`  out  1  sticky checksum error; constant 0 when checksum is compiled out

## Operation
- States:
  - IDLE: `in_ready`=0.
  - RECV: `in_ready`=1.
  - SETUP: `ram_we`=1; `ram_addr` and `ram_din` are stable.
  - STROBE: `ram_clk`=1.
  - RELEASE: `ram_clk`=0 and `ram_we`=0.
  - CHECK: `in_ready`=1; exists only with checksum compiled in.
- IDLE→RECV on `start`. The transition clears `ram_addr` to 0 and clears `done` and `err`.
- RECV→SETUP when `in_valid & in_ready`. The transition latches `in_data` into `ram_din`.
- SETUP→STROBE→RELEASE unconditionally.
- RELEASE with `ram_addr != MAX_ADDR`: `ram_addr` += 1, then →RECV.
- RELEASE with `ram_addr == MAX_ADDR`: `ram_addr` holds.
  - Checksum compiled out: →IDLE with `done`=1.
  - Checksum compiled in: →CHECK.
- `in_ready` is a combinational decode of the state (RECV or CHECK only).
- `busy` = state ≠ IDLE.
- `start` is honoured only in IDLE and RECV. In RECV it restarts at address 0. While SETUP, STROBE or RELEASE is active it is ignored, so a strobe is never cut short.
- `ram_addr` arithmetic is AW-bit. It never wraps, because the increment is gated at MAX_ADDR.
- `in_valid` with `in_data` in IDLE is ignored and not consumed.

## Timing
- Reset values: `in_ready`=0, `ram_din`=0, `ram_addr`=0, `ram_we`=0, `ram_clk`=0, `busy`=0, `done`=0, `err`=0; state IDLE.
- Reset mid-write drops `ram_clk` and `ram_we` immediately (asynchronously); the partial byte is lost.
- All outputs except `in_ready` are registered.
- Per byte, the accept cycle is N:
  - N+1: `ram_we`=1.
  - N+2: `ram_clk` rises. Address and data have been stable for ≥1 cycle.
  - N+3: `ram_clk` and `ram_we` are low.
  - N+4: `in_ready` is high again.
- Peak throughput is 1 byte per 4 cycles. A full frame takes 128×4 cycles minimum after `start`.
- `done` rises on the cycle after the final RELEASE (cycle 4·128 after the first accept, no stalls). It stays high until the next `start` or reset.
- Source stalls (in_valid=0 in RECV) hold all RAM outputs idle, with `ram_clk`=0 and `ram_we`=0.

## Configuration
- Macro: `FRAME_LOADER_CHECKSUM_EN`.
- Defined:
  - Maintains an 8-bit running sum (mod 256) of all accepted data bytes; the sum is cleared on `start`.
  - After MAX_ADDR is written, CHECK accepts one extra byte and goes to IDLE with `done`=1.
  - `err` = (extra byte ≠ sum) is set on the same cycle as `done`.
  - The checksum byte is never written to RAM.
- Undefined: no CHECK state and no accumulator; `err` is tied to 0; `done` follows the last data write.

## Structure
- Shared package/include `frame_loader_pkg`:
  - state encodings;
  - defaults for `DW`, `AW` and `MAX_ADDR` (also used by the display scan path).
- One sub-module, `frame_checksum`, instantiated only under the macro.
  - Inputs: clear and accumulate-enable.
  - Outputs: the 8-bit sum.
- The strobe sequencing stays inline in `frame_loader`.

## Test plan
- **Reset:** `rst`=0 mid-STROBE → `ram_clk`, `ram_we`, `busy`, `done`, `err` all 0 in the same cycle; after release, state is IDLE with `in_ready`=0.
- **Full frame:** `start`, then bytes 0x00..0x7F with `in_valid` held high:
  - each address k is written with k, with exactly one `ram_clk` rise per address while `ram_we`=1;
  - `done`=1 at cycle 512 after the first accept;
  - `ram_addr` stays at 127.
- **Stalled source:** random `in_valid` gaps → RAM contents identical to the full-frame case; no `ram_clk` edges during gaps.
- **Restart:**
  - `start` while in RECV at address 40 → next byte goes to address 0, `done` stays 0.
  - `start` during STROBE → ignored; the write completes.
- **Checksum (macro on):**
  - frame of 128×0x01, then 0x80 → `done`=1, `err`=0;
  - same frame, then 0x81 → `done`=1, `err`=1, and RAM address 127 still holds 0x01.
- **Idle input:** `in_valid`=1 in IDLE with no `start` → `in_ready`=0, no RAM activity, `done` unchanged.

Source files
------------

// File: rtl/frame_loader_pkg.sv
// ---------------------------------------------------------------------------
// frame_loader_pkg
//
// Shared definitions for the frame RAM loader and the display scan path:
//   - default frame RAM geometry (data width, address width, last address)
//   - loader FSM state encoding
// ---------------------------------------------------------------------------
package frame_loader_pkg;

    localparam int DW_DEF       = 8;    // frame RAM data width
    localparam int AW_DEF       = 8;    // frame RAM address width
    localparam int MAX_ADDR_DEF = 127;  // last RAM address of a frame (128x8)

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECV    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_RELEASE = 3'd4,
        ST_CHECK   = 3'd5
    } state_t;

endpackage

// File: rtl/frame_checksum.sv
// ---------------------------------------------------------------------------
// frame_checksum
//
// Running modulo-2^DW sum of accepted frame bytes.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   clear  in   synchronous clear of the sum (takes priority over acc_en)
//   acc_en in   add data into the sum this cycle
//   data   in   byte being accepted
//   sum    out  current running sum
// ---------------------------------------------------------------------------
module frame_checksum #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          acc_en,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] sum
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (acc_en) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/frame_loader.sv
// ---------------------------------------------------------------------------
// frame_loader
//
// Fills the frame RAM (addresses 0..MAX_ADDR) from a valid/ready byte stream,
// writing each byte with the two-phase ram_clk strobe:
//   SETUP   : ram_we=1, address/data stable
//   STROBE  : ram_clk=1 (RAM captures on the rising edge)
//   RELEASE : ram_clk=0, ram_we=0
// giving one byte per 4 cycles at best.
//
// Handshake: a byte transfers on a clk rising edge where in_valid and
// in_ready are both high. in_ready is a pure decode of the state (RECV or
// CHECK) and does not depend on in_valid; the source must hold in_data
// stable while in_valid is high and not yet accepted.
//
// Optional feature (macro FRAME_LOADER_CHECKSUM_EN): after the last data
// byte, one extra checksum byte is accepted in CHECK and compared with the
// modulo-256 sum of the frame; a mismatch sets the sticky err flag together
// with done. The checksum byte is never written to RAM. Without the macro,
// err is tied to 0 and done follows the last data write.
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   start      one-cycle pulse; (re)starts a frame at address 0
//              (honoured in IDLE and RECV only, so a strobe is never cut)
//   in_data    source byte       in_valid  source byte valid
//   in_ready   loader can accept a byte this cycle (combinational)
//   ram_din    RAM write data    ram_addr  RAM address
//   ram_we     RAM write enable  ram_clk   RAM strobe
//   busy       load in progress  done      sticky frame complete
//   err        sticky checksum error
//   state_dbg  current FSM state (frame_loader_pkg::state_t encoding)
// All outputs except in_ready and state_dbg come straight from flops.
// ---------------------------------------------------------------------------
module frame_loader
    import frame_loader_pkg::*;
#(
    parameter int            DW       = DW_DEF,
    parameter int            AW       = AW_DEF,
    parameter logic [AW-1:0] MAX_ADDR = AW'(MAX_ADDR_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] ram_din,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic          ram_clk,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [2:0]    state_dbg
);

    state_t state;
    state_t state_n;

    // Decoded events for the current cycle.
    logic restart;     // start honoured (IDLE or RECV)
    logic accept;      // data byte taken in RECV
    logic at_last;     // RELEASE of the final address

    logic [DW-1:0] din_n;
    logic [AW-1:0] addr_n;
    logic          we_n;
    logic          clk_n;
    logic          busy_n;
    logic          done_n;

    // A start in RECV takes precedence over a byte offered in the same
    // cycle: the frame restarts and that byte is dropped.
    assign restart  = start && (state == ST_IDLE || state == ST_RECV);
    assign accept   = (state == ST_RECV) && !start && in_valid;
    assign at_last  = (state == ST_RELEASE) && (ram_addr == MAX_ADDR);
    assign in_ready = (state == ST_RECV) || (state == ST_CHECK);
    assign state_dbg = state;

`ifdef FRAME_LOADER_CHECKSUM_EN
    logic [DW-1:0] sum;
    logic          chk_accept;
    logic          err_n;

    assign chk_accept = (state == ST_CHECK) && in_valid;

    frame_checksum #(.DW(DW)) u_checksum (
        .clk    (clk),
        .rst    (rst),
        .clear  (restart),
        .acc_en (accept),
        .data   (in_data),
        .sum    (sum)
    );
`endif

    // ---------------------------------------------------------------- state
    // Output flops share the state register so that an asynchronous reset
    // drops ram_clk/ram_we in the same instant as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ram_din  <= '0;
            ram_addr <= '0;
            ram_we   <= 1'b0;
            ram_clk  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            ram_din  <= din_n;
            ram_addr <= addr_n;
            ram_we   <= we_n;
            ram_clk  <= clk_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

`ifdef FRAME_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= err_n;
        end
    end
`else
    assign err = 1'b0;
`endif

    // ----------------------------------------------------------- next state
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (start) state_n = ST_RECV;
            end
            ST_RECV: begin
                if (start)         state_n = ST_RECV;
                else if (in_valid) state_n = ST_SETUP;
            end
            ST_SETUP:  state_n = ST_STROBE;
            ST_STROBE: state_n = ST_RELEASE;
            ST_RELEASE: begin
                if (ram_addr != MAX_ADDR) begin
                    state_n = ST_RECV;
                end else begin
`ifdef FRAME_LOADER_CHECKSUM_EN
                    state_n = ST_CHECK;
`else
                    state_n = ST_IDLE;
`endif
                end
            end
            ST_CHECK: begin
`ifdef FRAME_LOADER_CHECKSUM_EN
                if (in_valid) state_n = ST_IDLE;
`else
                state_n = ST_IDLE;
`endif
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Registered outputs are computed from the state being entered, so the
    // strobe lines line up exactly with SETUP/STROBE/RELEASE.
    always_comb begin
        din_n  = ram_din;
        addr_n = ram_addr;
        done_n = done;
        we_n   = (state_n == ST_SETUP) || (state_n == ST_STROBE);
        clk_n  = (state_n == ST_STROBE);
        busy_n = (state_n != ST_IDLE);

        if (restart) begin
            addr_n = '0;
            done_n = 1'b0;
        end
        if (accept) begin
            din_n = in_data;
        end
        // The increment is gated at MAX_ADDR, so the address never wraps.
        if (state == ST_RELEASE && ram_addr != MAX_ADDR) begin
            addr_n = ram_addr + AW'(1);
        end
`ifdef FRAME_LOADER_CHECKSUM_EN
        if (chk_accept) begin
            done_n = 1'b1;
        end
`else
        if (at_last) begin
            done_n = 1'b1;
        end
`endif
    end

`ifdef FRAME_LOADER_CHECKSUM_EN
    always_comb begin
        err_n = err;
        if (restart) begin
            err_n = 1'b0;
        end else if (chk_accept) begin
            err_n = (in_data != sum);
        end
    end
`endif

endmodule

// File: tb/tb_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_frame_loader
//
// Bench for frame_loader: a short per-cycle vector table, then frame-level
// sequences checked against a behavioural RAM and an expected-frame array.
// Works with and without FRAME_LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_frame_loader;
    import frame_loader_pkg::*;

    // ------------------------------------------------------- clock / reset
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] ram_din;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic       ram_clk;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    frame_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ram_din   (ram_din),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_clk   (ram_clk),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // ----------------------------------------------------- behavioural RAM
    logic [7:0] mem [128];
    int         rise_cnt [128];
    int         rise_total = 0;
    int         we_viol = 0;
    int         stall_viol = 0;

    always @(posedge ram_clk) begin
        rise_total++;
        if (!ram_we) begin
            we_viol++;
        end else if (ram_addr < 8'd128) begin
            mem[ram_addr] = ram_din;
            rise_cnt[ram_addr]++;
        end
    end

    // ---------------------------------------------------------- scoreboard
    int         checks = 0;
    int         failures = 0;
    logic [7:0] src_q [$];       // bytes still to be offered to the DUT
    logic [7:0] exp_mem [128];   // expected frame contents
    logic [7:0] exp_sum;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 128; k++) begin
            mem[k]      = 8'h00;
            rise_cnt[k] = 0;
        end
        rise_total = 0;
        we_viol    = 0;
        stall_viol = 0;
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        for (int k = 0; k < 128; k++) begin
            if (mem[k] !== exp_mem[k] || rise_cnt[k] != 1) bad++;
        end
        check(name, 64'(bad), 64'd0);
    endtask

    // -------------------------------------------------------- driver tasks
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers src_q bytes with random gaps until all are accepted.
    task automatic feed(input int stall_pct, input int budget,
                        output int first_acc, output bit ok);
        int n = 0;
        first_acc = -1;
        ok = 1'b1;
        while (src_q.size() > 0) begin
            if (n >= budget) begin
                ok = 1'b0;
                break;
            end
            @(negedge clk);
            start = 1'b0;
            if (32'($urandom_range(0, 99)) >= 32'(stall_pct)) begin
                in_valid = 1'b1;
                in_data  = src_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            #1;
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                void'(src_q.pop_front());
            end
            @(posedge clk); #1;
            n++;
            if (in_ready && (ram_clk || ram_we)) stall_viol++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at_cyc, output bit ok);
        ok = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                at_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // Builds a frame (k or random data) plus, when compiled in, the
    // correct checksum byte (or that byte + bad_delta).
    task automatic load_frame(input bit rand_data, input logic [7:0] fixed,
                              input bit use_fixed, input logic [7:0] bad_delta);
        exp_sum = 8'h00;
        src_q.delete();
        for (int k = 0; k < 128; k++) begin
            if (use_fixed)      exp_mem[k] = fixed;
            else if (rand_data) exp_mem[k] = 8'($urandom);
            else                exp_mem[k] = 8'(k);
            exp_sum = exp_sum + exp_mem[k];
            src_q.push_back(exp_mem[k]);
        end
`ifdef FRAME_LOADER_CHECKSUM_EN
        src_q.push_back(exp_sum + bad_delta);
`else
        if (bad_delta != 8'h00) exp_sum = exp_sum + bad_delta;
`endif
    endtask

    // ------------------------------------------------------- vector table
    typedef struct {
        logic       start;
        logic       valid;
        logic [7:0] data;
        logic       rdy;
        logic       busy;
        logic       we;
        logic       rclk;
        logic [7:0] addr;
        logic [7:0] din;
        logic       done;
    } vec_t;

    vec_t vecs [12];

    int   fa, dc, lat_exp, rt0, idle_bad;
    bit   ok, ok2;

    initial begin
        // inputs for one cycle -> outputs expected just after that edge
        vecs[0]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}; // idle input ignored
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}; // start -> RECV
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}; // stall
        vecs[3]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0}; // accept -> SETUP
        vecs[4]  = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'hA5, 1'b0}; // STROBE, data held
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0}; // RELEASE
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'hA5, 1'b0}; // RECV, addr+1
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0}; // restart in RECV
        vecs[8]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b0}; // accept
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h3C, 1'b0}; // start in STROBE ignored
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0}; // RELEASE
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h3C, 1'b0}; // RECV

        clear_model();
        do_reset();
        check("reset_outputs",
              {in_ready, busy, ram_we, ram_clk, ram_addr, ram_din, done, err, state_dbg},
              {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'(ST_IDLE)});

        // ---------------- per-cycle vectors
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start    = vecs[i].start;
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  {in_ready, busy, ram_we, ram_clk, ram_addr, ram_din, done, err},
                  {vecs[i].rdy, vecs[i].busy, vecs[i].we, vecs[i].rclk,
                   vecs[i].addr, vecs[i].din, vecs[i].done, 1'b0});
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        check("vec_ram0", {mem[0], 8'(rise_cnt[0])}, {8'h3C, 8'd2});

        // ---------------- full frame, valid held high
        do_reset();
        clear_model();
        load_frame(1'b0, 8'h00, 1'b0, 8'h00);
        pulse_start();
        feed(0, 2000, fa, ok);
        check("full_feed_ok", 64'(ok), 64'd1);
        wait_done(50, dc, ok2);
        check("full_done_seen", 64'(ok2), 64'd1);
`ifdef FRAME_LOADER_CHECKSUM_EN
        lat_exp = 4 * 128 + 1;   // checksum byte taken in CHECK right after
`else
        lat_exp = 4 * 128;
`endif
        check("full_done_latency", 64'(dc - fa), 64'(lat_exp));
        check_mem("full_ram");
        check("full_addr_hold", ram_addr, 8'd127);
        check("full_rises", 64'(rise_total), 64'd128);
        check("full_we_during_clk", 64'(we_viol), 64'd0);
        check("full_idle_after", {busy, in_ready, err}, 3'b000);

        // ---------------- idle input with done set
        rt0 = rise_total;
        idle_bad = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h5A;
        repeat (10) begin
            @(posedge clk); #1;
            if (in_ready || busy || ram_we || ram_clk) idle_bad++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("idle_quiet", 64'(idle_bad), 64'd0);
        check("idle_no_writes", 64'(rise_total - rt0), 64'd0);
        check("idle_done_kept", {7'd0, done}, 8'd1);

        // ---------------- stalled source, same frame
        clear_model();
        load_frame(1'b0, 8'h00, 1'b0, 8'h00);
        pulse_start();
        check("start_clears_done", {7'd0, done}, 8'd0);
        feed(50, 20000, fa, ok);
        check("stall_feed_ok", 64'(ok), 64'd1);
        wait_done(50, dc, ok2);
        check("stall_done_seen", 64'(ok2), 64'd1);
        check_mem("stall_ram");
        check("stall_rises", 64'(rise_total), 64'd128);
        check("stall_quiet_gaps", 64'(stall_viol), 64'd0);

        // ---------------- random data, random stalls
        clear_model();
        load_frame(1'b1, 8'h00, 1'b0, 8'h00);
        pulse_start();
        feed(30, 20000, fa, ok);
        wait_done(50, dc, ok2);
        check("rand_done_seen", {6'd0, ok, ok2}, 8'd3);
        check_mem("rand_ram");
        check("rand_err", {7'd0, err}, 8'd0);

        // ---------------- restart in RECV at address 40
        clear_model();
        pulse_start();
        src_q.delete();
        for (int k = 0; k < 40; k++) src_q.push_back(8'(8'h80 + k));
        feed(0, 1000, fa, ok);
        repeat (4) @(posedge clk);
        #1;
        check("restart_pre", {in_ready, ram_addr}, {1'b1, 8'd40});
        pulse_start();
        check("restart_post", {in_ready, done, ram_addr}, {1'b1, 1'b0, 8'd0});
        src_q.push_back(8'hEE);
        feed(0, 100, fa, ok);
        repeat (4) @(posedge clk);
        #1;
        check("restart_write", {mem[0], ram_addr, 7'd0, done}, {8'hEE, 8'd1, 8'd0});

        // ---------------- reset mid-STROBE
        pulse_start();
        src_q.push_back(8'h11);
        feed(0, 100, fa, ok);
        ok2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ram_clk) begin
                ok2 = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("rst_reached_strobe", 64'(ok2), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_drop", {ram_clk, ram_we, busy, done, err}, 5'b00000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_idle", {in_ready, busy, state_dbg}, {1'b0, 1'b0, 3'(ST_IDLE)});

`ifdef FRAME_LOADER_CHECKSUM_EN
        // ---------------- checksum good / bad
        clear_model();
        load_frame(1'b0, 8'h01, 1'b1, 8'h00);
        check("cks_model_sum", exp_sum, 8'h80);
        pulse_start();
        feed(0, 2000, fa, ok);
        wait_done(50, dc, ok2);
        check("cks_good", {ok2, done, err}, 3'b110);
        clear_model();
        load_frame(1'b0, 8'h01, 1'b1, 8'h01);
        pulse_start();
        feed(20, 5000, fa, ok);
        wait_done(50, dc, ok2);
        check("cks_bad", {ok2, done, err}, 3'b111);
        check("cks_not_written", {mem[127], 8'(rise_cnt[127]), 8'(rise_total)},
              {8'h01, 8'd1, 8'd128});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
